// File: rtl/eth_tx_sched.sv
// Round-robin scheduler sharing one RMII tx path; enforces IFG and start timeout.
// Optional frame/error statistics are built when ETH_TX_SCHED_STATS_EN is defined.
module eth_tx_sched #(
    parameter int pNUM_REQ  = 4,
    parameter int pIFG_CYC  = 48,
    parameter int pSTART_TO = 64
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic [pNUM_REQ-1:0] Req,
    input  logic                Tx_En,
    output logic [pNUM_REQ-1:0] Gnt,
    output logic                Eth_Pkt_Rdy,
    output logic [pNUM_REQ-1:0] Frame_Done,
    output logic                Tx_Err,
    output logic                Busy,
    output logic [15:0]         Tx_Frame_Cnt,
    output logic [15:0]         Tx_Err_Cnt
);

    localparam int PW   = $clog2(pNUM_REQ);
    localparam int CMAX = (pIFG_CYC > pSTART_TO) ? pIFG_CYC : pSTART_TO;
    localparam int CW   = $clog2(CMAX);

    typedef logic [PW:0]   idx_t;
    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t START_LAST = cnt_t'(pSTART_TO - 1);
    localparam cnt_t IFG_LAST   = cnt_t'(pIFG_CYC - 1);
    localparam idx_t NREQ       = idx_t'(pNUM_REQ);
    localparam ptr_t PTR_LAST   = ptr_t'(pNUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, WAIT_START, BUSY, IFG} state_t;

    state_t              state_q, state_d;
    logic [pNUM_REQ-1:0] gnt_q, gnt_d;
    logic [pNUM_REQ-1:0] done_q, done_d;
    ptr_t                ptr_q, ptr_d;
    ptr_t                win_q, win_d;
    cnt_t                cnt_q, cnt_d;
    logic                rdy_q, rdy_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    logic found;
    ptr_t pick;
    ptr_t win_nxt;
    idx_t idx;

    // First asserted request at or above the RR pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < pNUM_REQ; i++) begin
            idx = idx_t'(ptr_q) + idx_t'(i);
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && Req[idx[PW-1:0]]) begin
                found = 1'b1;
                pick  = idx[PW-1:0];
            end
        end
    end

    assign win_nxt = (win_q == PTR_LAST) ? '0 : win_q + 1'b1;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        rdy_d   = 1'b0;
        err_d   = 1'b0;
        done_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = WAIT_START;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    win_d       = pick;
                    rdy_d       = 1'b1;
                    cnt_d       = '0;
                end
            end
            WAIT_START: begin
                if (Tx_En) begin
                    state_d = BUSY;
                end else if (cnt_q == START_LAST) begin
                    state_d = IFG;
                    gnt_d   = '0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    ptr_d   = win_nxt;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BUSY: begin
                if (!Tx_En) begin
                    state_d       = IFG;
                    gnt_d         = '0;
                    done_d[win_q] = 1'b1;
                    cnt_d         = '0;
                    ptr_d         = win_nxt;
                end
            end
            IFG: begin
                if (cnt_q == IFG_LAST) state_d = IDLE;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign Gnt         = gnt_q;
    assign Eth_Pkt_Rdy = rdy_q;
    assign Frame_Done  = done_q;
    assign Tx_Err      = err_q;
    assign Busy        = busy_q;

`ifdef ETH_TX_SCHED_STATS_EN
    logic [15:0] fcnt_q, fcnt_d;
    logic [15:0] ecnt_q, ecnt_d;

    // Saturating counters; only reset clears them.
    always_comb begin
        fcnt_d = fcnt_q;
        ecnt_d = ecnt_q;
        if (|done_q && fcnt_q != 16'hFFFF) fcnt_d = fcnt_q + 16'd1;
        if (err_q && ecnt_q != 16'hFFFF)   ecnt_d = ecnt_q + 16'd1;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            fcnt_q <= '0;
            ecnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
            ecnt_q <= ecnt_d;
        end
    end

    assign Tx_Frame_Cnt = fcnt_q;
    assign Tx_Err_Cnt   = ecnt_q;
`else
    assign Tx_Frame_Cnt = 16'h0000;
    assign Tx_Err_Cnt   = 16'h0000;
`endif

endmodule
